vm_change_dispenser: RTL and testbench
======================================

# vm_change_dispenser

Change-return back end of the vending machine. Accepts a change amount from the vending FSM over a valid/ready handshake and drives three coin-hopper solenoids (quarter, dime, nickel) one coin at a time with fixed-width pulses. Uses a greedy, largest-denomination-first selection that skips empty hoppers. Reports completion, coin count and any shortfall back to the vending FSM.

## Interface
Parameters:
- PULSE_CYCLES, 4: cycles a coin line is held high per coin (≥1).
- GAP_CYCLES, 4: cycles all coin lines are held low between coins (≥1).
- AMT_W, 8: width of amount fields, in nickel units (1 unit = 5 cents).

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  change request present.
- req_amount  in  AMT_W  change owed, in nickel units.
- req_ready  out  1  block idle and able to accept a request.
- empty_q / empty_d / empty_n  in  1 each  hopper-empty flags; 1 = no coins in that hopper.
- coin_q / coin_d / coin_n  out  1 each  solenoid drive; at most one is high at any time.
- done  out  1  one-cycle pulse at the end of every transaction.
- fault  out  1  valid with done; 1 = change could not be fully paid.
- shortfall  out  AMT_W  valid with done; unpaid remainder in nickel units (0 when fault = 0).
- coin_count  out  8  coins dispensed in the transaction; valid with done; saturates at 255.

## Operation
- Denomination values: Q = 5, D = 2, N = 1 (nickel units).
- States:
  - IDLE: req_ready = 1. On req_valid && req_ready, latch req_amount into rem, clear coin_count, go to SELECT.
  - SELECT: sample the empty_* inputs.
    - rem == 0: go to DONE.
    - Otherwise pick the first of Q, D, N with rem ≥ value and empty = 0. If one is found, go to PULSE; if none, go to FAULT.
  - PULSE: on entry, rem −= value and coin_count += 1 (saturating). The selected coin line is high for the whole state. After PULSE_CYCLES cycles, go to GAP.
  - GAP: all coin lines low. After GAP_CYCLES cycles, go to SELECT.
  - DONE: done = 1, fault = 0, shortfall = 0. Next state is IDLE.
  - FAULT: done = 1, fault = 1, shortfall = rem. Next state is IDLE.
- Selection is strictly greedy with skip-if-empty; no backtracking. Example: rem = 3 with nickels empty pays one dime, then faults with shortfall 1.
- The empty_* inputs are sampled only in SELECT. Changes during PULSE or GAP do not affect the coin in flight.
- req_valid while busy (req_ready = 0) is ignored; the request is not queued.
- Subtraction cannot underflow: rem ≥ value is guaranteed by the selection rule.
- All outputs are registered.

## Timing
- Reset values: state IDLE, req_ready = 1, every coin line = 0, done = 0, fault = 0, shortfall = 0, coin_count = 0.
- Reset asserted mid-operation: coin lines drop immediately (asynchronously); the request is abandoned and done is not issued.
- Accept at edge T:
  - SELECT is active in the cycle after T.
  - The first coin line rises one cycle after SELECT.
- Per coin: 1 (SELECT) + PULSE_CYCLES + GAP_CYCLES cycles.
- Zero amount: done is high exactly two cycles after the accept edge; no coin line toggles.
- done, fault, shortfall and coin_count are valid together for exactly one cycle.
- req_ready returns to 1 in the cycle after done. A new request may be accepted on that edge.

## Structure
- Shared package vm_pkg holds:
  - the state enum (IDLE, SELECT, PULSE, GAP, DONE, FAULT);
  - denomination constants VAL_Q = 5, VAL_D = 2, VAL_N = 1;
  - the coin-select encoding (COIN_NONE, COIN_Q, COIN_D, COIN_N).
- One natural sub-module, vm_coin_select: combinational greedy picker with inputs rem and empty_*, outputs coin select and value. It is unit-testable on its own.
- The pulse and gap timers share one down-counter sized to the larger of PULSE_CYCLES and GAP_CYCLES.

## Test plan
- Full change: amount 8, no hoppers empty → pulses Q, D, N in that order, each exactly 4 cycles high with 4-cycle gaps; done with fault = 0, coin_count = 3, shortfall = 0.
- Zero amount: amount 0 → no coin pulses; done two cycles after accept; coin_count = 0.
- Empty-hopper skip: empty_q = 1, amount 5 → D, D, N; coin_count = 3; fault = 0.
- Shortfall: empty_n = 1, amount 3 → one D pulse; then done with fault = 1, shortfall = 1, coin_count = 1.
- Busy rejection and back-to-back requests:
  - second req_valid with amount 2 during a transaction → ignored, no extra coins;
  - the same request issued in the cycle after done → accepted on that edge, one D pulse.
- Reset mid-pulse: assert rst_n = 0 during a Q pulse → coin_q = 0 immediately; after release req_ready = 1, done never pulses, all outputs at reset values.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine change dispenser.
// State enum, coin-select encoding and denomination values (nickel units).
package vm_pkg;

   // Denomination values in nickel units (1 unit = 5 cents).
   localparam int unsigned VAL_Q = 5;
   localparam int unsigned VAL_D = 2;
   localparam int unsigned VAL_N = 1;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      PULSE,
      GAP,
      DONE,
      FAULT
   } state_e;

   typedef enum logic [1:0] {
      COIN_NONE,
      COIN_Q,
      COIN_D,
      COIN_N
   } coin_e;

   function automatic int unsigned coin_value(coin_e c);
      int unsigned v;
      v = 0;
      case (c)
         COIN_Q:  v = VAL_Q;
         COIN_D:  v = VAL_D;
         COIN_N:  v = VAL_N;
         default: v = 0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/vm_coin_select.sv
// Greedy coin picker: largest denomination that fits rem and is not empty.
// Ports: rem, empty_q/d/n in; coin (select), value (nickel units) out.
module vm_coin_select
   import vm_pkg::*;
#(
   parameter int AMT_W = 8
) (
   input  logic [AMT_W-1:0] rem,
   input  logic             empty_q,
   input  logic             empty_d,
   input  logic             empty_n,
   output coin_e            coin,
   output logic [AMT_W-1:0] value
);

   logic ok_q;
   logic ok_d;
   logic ok_n;
   logic use_q;
   logic use_d;
   logic use_n;

   assign ok_q = !empty_q && (rem >= AMT_W'(VAL_Q));
   assign ok_d = !empty_d && (rem >= AMT_W'(VAL_D));
   assign ok_n = !empty_n && (rem >= AMT_W'(VAL_N));

   // Priority folded into mutually exclusive terms so the decode is one-hot.
   assign use_q = ok_q;
   assign use_d = !ok_q && ok_d;
   assign use_n = !ok_q && !ok_d && ok_n;

   always_comb begin
      coin = COIN_NONE;
      unique case (1'b1)
         use_q:   coin = COIN_Q;
         use_d:   coin = COIN_D;
         use_n:   coin = COIN_N;
         default: coin = COIN_NONE;
      endcase
   end

   assign value = AMT_W'(coin_value(coin));

endmodule

// File: rtl/vm_change_dispenser.sv
// Change-return back end: pays an amount one coin at a time via hoppers.
// Ports: clk, rst_n; req_valid/req_amount/req_ready handshake; empty_q/d/n
// hopper flags; coin_q/d/n solenoids; done, fault, shortfall, coin_count.
module vm_change_dispenser
   import vm_pkg::*;
#(
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 4,
   parameter int AMT_W        = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   input  logic [AMT_W-1:0] req_amount,
   output logic             req_ready,
   input  logic             empty_q,
   input  logic             empty_d,
   input  logic             empty_n,
   output logic             coin_q,
   output logic             coin_d,
   output logic             coin_n,
   output logic             done,
   output logic             fault,
   output logic [AMT_W-1:0] shortfall,
   output logic [7:0]       coin_count
);

   // One down-counter serves both the pulse and the gap phase.
   localparam int CMAX  = (PULSE_CYCLES > GAP_CYCLES) ?
                          PULSE_CYCLES : GAP_CYCLES;
   localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

   state_e           state;
   logic [AMT_W-1:0] rem;
   logic [CNT_W-1:0] cnt;
   coin_e            sel_coin;
   logic [AMT_W-1:0] sel_value;

   vm_coin_select #(
      .AMT_W(AMT_W)
   ) u_sel (
      .rem    (rem),
      .empty_q(empty_q),
      .empty_d(empty_d),
      .empty_n(empty_n),
      .coin   (sel_coin),
      .value  (sel_value)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rem        <= '0;
         cnt        <= '0;
         req_ready  <= 1'b1;
         coin_q     <= 1'b0;
         coin_d     <= 1'b0;
         coin_n     <= 1'b0;
         done       <= 1'b0;
         fault      <= 1'b0;
         shortfall  <= '0;
         coin_count <= '0;
      end else begin
         // Result fields are one-cycle strobes.
         done      <= 1'b0;
         fault     <= 1'b0;
         shortfall <= '0;
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  rem        <= req_amount;
                  coin_count <= '0;
                  req_ready  <= 1'b0;
                  state      <= SELECT;
               end
            end
            SELECT: begin
               if (rem == '0) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else if (sel_coin == COIN_NONE) begin
                  done      <= 1'b1;
                  fault     <= 1'b1;
                  shortfall <= rem;
                  state     <= FAULT;
               end else begin
                  rem    <= rem - sel_value;
                  coin_q <= (sel_coin == COIN_Q);
                  coin_d <= (sel_coin == COIN_D);
                  coin_n <= (sel_coin == COIN_N);
                  cnt    <= PULSE_LD;
                  state  <= PULSE;
                  if (coin_count != 8'hFF) begin
                     coin_count <= coin_count + 8'd1;
                  end
               end
            end
            PULSE: begin
               if (cnt == '0) begin
                  coin_q <= 1'b0;
                  coin_d <= 1'b0;
                  coin_n <= 1'b0;
                  cnt    <= GAP_LD;
                  state  <= GAP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            GAP: begin
               if (cnt == '0) begin
                  state <= SELECT;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE, FAULT: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               coin_q    <= 1'b0;
               coin_d    <= 1'b0;
               coin_n    <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Scoreboard bench for vm_change_dispenser.
// Driver pushes model results; a monitor checks coins, timing and results.
module tb_vm_change_dispenser;

   localparam int P     = 4;
   localparam int G     = 4;
   localparam int AW    = 8;
   localparam int PER   = 1 + P + G;
   localparam int MAXC  = 64;

   typedef struct {
      int n;
      int fault;
      int shortfall;
      logic [2:0] coin [MAXC];
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic [AW-1:0] req_amount = '0;
   logic          req_ready;
   logic          empty_q = 1'b0;
   logic          empty_d = 1'b0;
   logic          empty_n = 1'b0;
   logic          coin_q;
   logic          coin_d;
   logic          coin_n;
   logic          done;
   logic          fault;
   logic [AW-1:0] shortfall;
   logic [7:0]    coin_count;

   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   bit   mon_in_txn = 1'b0;

   vm_change_dispenser #(
      .PULSE_CYCLES(P),
      .GAP_CYCLES  (G),
      .AMT_W       (AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_amount(req_amount),
      .req_ready (req_ready),
      .empty_q   (empty_q),
      .empty_d   (empty_d),
      .empty_n   (empty_n),
      .coin_q    (coin_q),
      .coin_d    (coin_d),
      .coin_n    (coin_n),
      .done      (done),
      .fault     (fault),
      .shortfall (shortfall),
      .coin_count(coin_count)
   );

   always #5 clk = ~clk;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
      end
   endtask

   // Greedy change payout computed directly from the denomination rules.
   function automatic exp_t model(int amt, bit eq, bit ed, bit en);
      exp_t e;
      int rem;
      rem = amt;
      e.n = 0;
      for (int i = 0; i < MAXC; i++) e.coin[i] = 3'b000;
      while (rem > 0) begin
         if (!eq && rem >= 5) begin
            e.coin[e.n] = 3'b100; rem -= 5;
         end else if (!ed && rem >= 2) begin
            e.coin[e.n] = 3'b010; rem -= 2;
         end else if (!en) begin
            e.coin[e.n] = 3'b001; rem -= 1;
         end else begin
            break;
         end
         e.n++;
      end
      e.fault = (rem != 0) ? 1 : 0;
      e.shortfall = rem;
      return e;
   endfunction

   task automatic wait_ready();
      int k;
      k = 0;
      while (!req_ready && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL ready_timeout: got 0 expected 1");
      end
   endtask

   task automatic send(int amt, bit eq, bit ed, bit en);
      @(negedge clk);
      wait_ready();
      empty_q    = eq;
      empty_d    = ed;
      empty_n    = en;
      req_amount = AW'(amt);
      req_valid  = 1'b1;
      exp_q.push_back(model(amt, eq, ed, en));
      @(negedge clk);
      req_valid  = 1'b0;
   endtask

   // Monitor: tracks accept, then expects every cycle's outputs from timing.
   initial begin : mon
      int   cyc;
      int   acc;
      int   o;
      bit   prev_ready;
      logic [2:0] exp_coin;
      bit   exp_done;
      exp_t cur;
      cyc = 0;
      acc = 0;
      prev_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!rst_n) begin
            mon_in_txn = 1'b0;
            check("reset_state",
                  {10'd0, req_ready, coin_q, coin_d, coin_n,
                   done, fault, shortfall, coin_count},
                  {10'd0, 1'b1, 21'd0});
         end else begin
            if (req_valid && prev_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_accept", 1, 0);
               end else begin
                  cur = exp_q.pop_front();
                  mon_in_txn = 1'b1;
                  acc = cyc;
               end
            end
            exp_coin = 3'b000;
            exp_done = 1'b0;
            if (mon_in_txn) begin
               o = cyc - acc;
               for (int i = 0; i < cur.n; i++)
                  if (o >= 1 + i*PER && o < 1 + i*PER + P)
                     exp_coin = cur.coin[i];
               exp_done = (o == cur.n*PER + 1);
            end
            check("coin_lines", {29'd0, coin_q, coin_d, coin_n},
                  {29'd0, exp_coin});
            check("done", {31'd0, done}, {31'd0, exp_done});
            check("req_ready", {31'd0, req_ready}, {31'd0, !mon_in_txn});
            if (exp_done) begin
               check("fault", {31'd0, fault}, 32'(cur.fault));
               check("shortfall", {24'd0, shortfall}, 32'(cur.shortfall));
               check("coin_count", {24'd0, coin_count}, 32'(cur.n));
               mon_in_txn = 1'b0;
            end
         end
         prev_ready = req_ready;
      end
   end

   initial begin : drv
      int k;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      send(8, 0, 0, 0);
      send(0, 0, 0, 0);
      send(5, 1, 0, 0);
      send(3, 0, 0, 1);
      send(13, 1, 1, 0);
      send(7, 1, 1, 1);

      // Busy rejection, then the same request held into the idle cycle.
      send(8, 0, 0, 0);
      repeat (5) @(negedge clk);
      req_amount = 8'd2;
      empty_q = 1'b0;
      empty_d = 1'b0;
      empty_n = 1'b0;
      req_valid = 1'b1;
      k = 0;
      while (!req_ready && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (req_ready) exp_q.push_back(model(2, 0, 0, 0));
      else check("busy_ready_timeout", 0, 1);
      @(negedge clk);
      req_valid = 1'b0;

      for (int t = 0; t < 30; t++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(int'($urandom_range(0, 30)),
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0);
      end

      // Reset asserted in the middle of a quarter pulse.
      send(5, 0, 0, 0);
      k = 0;
      while (!coin_q && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("q_pulse_seen", {31'd0, coin_q}, 32'd1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset",
            {10'd0, req_ready, coin_q, coin_d, coin_n,
             done, fault, shortfall, coin_count},
            {10'd0, 1'b1, 21'd0});
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      send(2, 0, 0, 0);
      k = 0;
      while ((exp_q.size() != 0 || mon_in_txn) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 3000) check("drain_timeout", 0, 1);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
